// File: rtl/dso_pkg.sv
// Shared capture-engine types and default geometry for the DSO wave buffer.
package dso_pkg;
    localparam int DSO_ADDR_WIDTH = 10;
    localparam int DSO_DATA_WIDTH = 8;
    localparam int DSO_DEPTH      = 1 << DSO_ADDR_WIDTH;
    localparam int DSO_PRE_TRIG   = 512;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        ARMED,
        POST_FILL,
        DONE
    } cap_state_t;
endpackage

// File: rtl/dso_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module dso_capture_ram
    import dso_pkg::*;
#(
    parameter int ADDR_WIDTH = DSO_ADDR_WIDTH,
    parameter int DATA_WIDTH = DSO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Array contents are never reset; only the output register is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/dso_wave_capture.sv
// DSO capture engine: decimation, level/edge trigger and pre/post-trigger
// fill of a circular sample buffer with a registered random-access read port.
module dso_wave_capture
    import dso_pkg::*;
#(
    parameter int ADDR_WIDTH = DSO_ADDR_WIDTH,
    parameter int DATA_WIDTH = DSO_DATA_WIDTH,
    parameter int PRE_TRIG   = DSO_PRE_TRIG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ad_valid,
    input  logic [DATA_WIDTH-1:0] ad_data,
    input  logic                  wave_run,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_edge,
    input  logic [9:0]            deci_rate,
    input  logic                  ram_refresh,
    input  logic [ADDR_WIDTH-1:0] wave_rd_addr,
    output logic [DATA_WIDTH-1:0] wave_rd_data,
    output logic                  wave_ready,
    output logic [ADDR_WIDTH-1:0] wave_trig_addr
);
    localparam int               CNT_W     = ADDR_WIDTH + 1;
    localparam int               POST_LEN  = (1 << ADDR_WIDTH) - PRE_TRIG;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_TRIG - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_LEN - 1);

    cap_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [CNT_W-1:0]      fill_cnt;
    logic [9:0]            deci_lat, deci_cnt;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic                  refresh_p1, refresh_p2;
    logic                  capturing, rearm, accept, crossed, trig_hit, start;

    assign capturing = (state == PRE_FILL) || (state == ARMED) || (state == POST_FILL);
    assign rearm     = refresh_p1 && !refresh_p2 && (state != IDLE);
    assign accept    = capturing && wave_run && !rearm && ad_valid && (deci_cnt == '0);
    assign crossed   = trig_edge ? ((prev <  trig_level) && (ad_data >= trig_level))
                                 : ((prev >= trig_level) && (ad_data <  trig_level));
    assign trig_hit  = (state == ARMED) && accept && prev_valid && crossed;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        if (!wave_run) begin
            state_nxt = IDLE;
        end else if ((state == IDLE) || rearm) begin
            state_nxt = PRE_FILL;
            start     = 1'b1;
        end else begin
            case (state)
                PRE_FILL:  if (accept && (fill_cnt == PRE_LAST)) state_nxt = ARMED;
                ARMED:     if (trig_hit) state_nxt = (POST_LEN == 1) ? DONE : POST_FILL;
                POST_FILL: if (accept && (fill_cnt == POST_LAST)) state_nxt = DONE;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            fill_cnt       <= '0;
            deci_lat       <= '0;
            deci_cnt       <= '0;
            prev           <= '0;
            prev_valid     <= 1'b0;
            refresh_p1     <= 1'b0;
            refresh_p2     <= 1'b0;
            wave_ready     <= 1'b0;
            wave_trig_addr <= '0;
        end else begin
            state      <= state_nxt;
            // ram_refresh edge detect: p1/p2 stage boundary
            refresh_p1 <= ram_refresh;
            refresh_p2 <= refresh_p1;
            wave_ready <= (state_nxt == DONE);
            if (start) begin
                wr_ptr     <= '0;
                fill_cnt   <= '0;
                prev_valid <= 1'b0;
                deci_cnt   <= '0;
                deci_lat   <= deci_rate;
            end else begin
                if (capturing && ad_valid && (deci_lat > 10'd1)) begin
                    deci_cnt <= (deci_cnt == deci_lat - 10'd1) ? '0 : deci_cnt + 10'd1;
                end
                if (accept) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    prev       <= ad_data;
                    prev_valid <= 1'b1;
                    case (state)
                        // A crossing straddling the end of the pre-trigger window is not a trigger.
                        PRE_FILL: begin
                            if (fill_cnt == PRE_LAST) begin
                                fill_cnt   <= '0;
                                prev_valid <= 1'b0;
                            end else begin
                                fill_cnt <= fill_cnt + 1'b1;
                            end
                        end
                        ARMED: begin
                            if (trig_hit) begin
                                fill_cnt       <= CNT_W'(1);
                                wave_trig_addr <= wr_ptr;
                            end
                        end
                        POST_FILL: fill_cnt <= fill_cnt + 1'b1;
                        default:   ;
                    endcase
                end
            end
        end
    end

    dso_capture_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .wr_addr(wr_ptr),
        .wr_data(ad_data),
        .rd_addr(wave_rd_addr),
        .rd_data(wave_rd_data)
    );
endmodule

// File: tb/tb_dso_wave_capture.sv
// Bench for dso_wave_capture: scenario table for trigger modes plus
// hand-written abort, refresh and reset sequences; reads are scoreboarded.
`timescale 1ns/1ps
module tb_dso_wave_capture;
    import dso_pkg::*;

    localparam int AW = DSO_ADDR_WIDTH;
    localparam int DW = DSO_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          ad_valid;
    logic [DW-1:0] ad_data;
    logic          wave_run;
    logic [DW-1:0] trig_level;
    logic          trig_edge;
    logic [9:0]    deci_rate;
    logic          ram_refresh;
    logic [AW-1:0] wave_rd_addr;
    logic [DW-1:0] wave_rd_data;
    logic          wave_ready;
    logic [AW-1:0] wave_trig_addr;

    always #5 clk = ~clk;

    dso_wave_capture #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .PRE_TRIG  (DSO_PRE_TRIG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ad_valid      (ad_valid),
        .ad_data       (ad_data),
        .wave_run      (wave_run),
        .trig_level    (trig_level),
        .trig_edge     (trig_edge),
        .deci_rate     (deci_rate),
        .ram_refresh   (ram_refresh),
        .wave_rd_addr  (wave_rd_addr),
        .wave_rd_data  (wave_rd_data),
        .wave_ready    (wave_ready),
        .wave_trig_addr(wave_trig_addr)
    );

    typedef struct packed {
        logic              rising;
        logic [9:0]        deci;
        int                chg_at;
        logic [AW-1:0]     exp_trig;
        int                exp_samples;
        logic [2:0][AW-1:0] ra;
        logic [2:0][DW-1:0] rd;
    } scen_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rd_vec_t;

    scen_t         scen [3];
    rd_vec_t       rd_tbl [$];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad   = 0;
    int            k     = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_reads(input string name);
        logic [DW-1:0] e;
        foreach (rd_tbl[i]) begin
            wave_rd_addr = rd_tbl[i].addr;
            exp_q.push_back(rd_tbl[i].data);
            tick();
            e = exp_q.pop_front();
            check($sformatf("%s_rd[%0d]", name, rd_tbl[i].addr), 32'(wave_rd_data), 32'(e));
        end
        rd_tbl.delete();
    endtask

    task automatic go_idle();
        wave_run    = 1'b0;
        ram_refresh = 1'b0;
        ad_valid    = 1'b0;
        tick();
    endtask

    task automatic start_capture();
        ad_valid = 1'b0;
        wave_run = 1'b1;
        tick();
        k = 0;
    endtask

    task automatic drive_ramp(input int n);
        for (int c = 0; c < n; c++) begin
            ad_valid = 1'b1;
            ad_data  = DW'(k);
            k++;
            tick();
        end
    endtask

    task automatic run_capture(input int budget, input int chg_at, output int samples, output bit ok);
        samples = 0;
        ok      = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c == chg_at) deci_rate = 10'd8;
            ad_valid = 1'b1;
            ad_data  = DW'(k);
            k++;
            samples++;
            tick();
            if (wave_ready) begin
                ok = 1'b1;
                break;
            end
        end
        ad_valid = 1'b0;
    endtask

    initial begin
        int  samples;
        bit  ok;
        int  rises;
        logic last_rdy;

        scen[0] = '{1'b1, 10'd0, -1, 10'd612, 1124,
                    {10'd99, 10'd611, 10'd612}, {8'd99, 8'd99, 8'd100}};
        scen[1] = '{1'b0, 10'd0, -1, 10'd768, 1280,
                    {10'd768, 10'd767, 10'd768}, {8'd0, 8'd255, 8'd0}};
        scen[2] = '{1'b1, 10'd4, 100, 10'd537, 4193,
                    {10'd536, 10'd538, 10'd537}, {8'd96, 8'd104, 8'd100}};

        rst = 1'b1; ad_valid = 1'b0; ad_data = '0; wave_run = 1'b0;
        trig_level = 8'd100; trig_edge = 1'b1; deci_rate = '0;
        ram_refresh = 1'b0; wave_rd_addr = '0;
        tick();
        tick();
        check("reset_ready", 32'(wave_ready), 0);
        check("reset_trig",  32'(wave_trig_addr), 0);
        check("reset_rd",    32'(wave_rd_data), 0);
        rst = 1'b0;
        tick();

        foreach (scen[s]) begin
            trig_edge = scen[s].rising;
            deci_rate = scen[s].deci;
            start_capture();
            run_capture(6000, scen[s].chg_at, samples, ok);
            check($sformatf("s%0d_ready_seen", s), 32'(ok), 1);
            check($sformatf("s%0d_samples", s), 32'(samples), 32'(scen[s].exp_samples));
            check($sformatf("s%0d_trig", s), 32'(wave_trig_addr), 32'(scen[s].exp_trig));
            for (int j = 0; j < 3; j++) rd_tbl.push_back('{scen[s].ra[j], scen[s].rd[j]});
            run_reads($sformatf("s%0d", s));
            go_idle();
            check($sformatf("s%0d_ready_clr", s), 32'(wave_ready), 0);
        end

        // Abort during POST_FILL, then a full fresh capture.
        trig_edge = 1'b1;
        deci_rate = '0;
        start_capture();
        drive_ramp(700);
        wave_run = 1'b0;
        tick();
        check("abort_ready", 32'(wave_ready), 0);
        check("abort_trig_kept", 32'(wave_trig_addr), 612);
        rises = 0;
        for (int c = 0; c < 300; c++) begin
            ad_valid = 1'b1;
            ad_data  = DW'(c);
            tick();
            if (wave_ready) rises++;
        end
        check("abort_idle_ready", 32'(rises), 0);
        start_capture();
        run_capture(3000, -1, samples, ok);
        check("rerun_ready_seen", 32'(ok), 1);
        check("rerun_samples", 32'(samples), 1124);
        check("rerun_trig", 32'(wave_trig_addr), 612);

        // Refresh held high in DONE: one restart, one new ready.
        ram_refresh = 1'b1;
        ad_valid = 1'b1;
        ad_data = DW'(k); k++;
        tick();
        check("refresh_ready_hold", 32'(wave_ready), 1);
        ad_data = DW'(k); k++;
        tick();
        check("refresh_ready_drop", 32'(wave_ready), 0);
        rises    = 0;
        last_rdy = wave_ready;
        for (int c = 0; c < 3000; c++) begin
            ram_refresh = (c < 254);
            ad_valid    = 1'b1;
            ad_data     = DW'(k);
            k++;
            tick();
            if (wave_ready && !last_rdy) rises++;
            last_rdy = wave_ready;
        end
        check("refresh_rises", 32'(rises), 1);
        check("refresh_ready_end", 32'(wave_ready), 1);
        go_idle();

        // Asynchronous reset while ARMED.
        start_capture();
        wave_rd_addr = 10'd5;
        drive_ramp(600);
        check("armed_rd", 32'(wave_rd_data), 5);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ready", 32'(wave_ready), 0);
        check("rst_async_trig",  32'(wave_trig_addr), 0);
        check("rst_async_rd",    32'(wave_rd_data), 0);
        wave_run = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ad_valid = 1'b1;
            ad_data  = 8'hAA;
            tick();
        end
        ad_valid = 1'b0;
        check("post_rst_ready", 32'(wave_ready), 0);
        for (int a = 0; a < 4; a++) rd_tbl.push_back('{AW'(a), DW'(a)});
        run_reads("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dso_wave_capture.md
Name: dso_wave_capture

Overview:
- Capture engine feeding the DSO register/AXI slave.
- Decimates the 8-bit ADC sample stream and detects the level/edge trigger.
- Fills a 1024x8 circular buffer with a fixed pre-trigger window.
- Reports wave_ready and the trigger address, and serves random-access reads of the buffer with 1-cycle latency.

Parameters:
- ADDR_WIDTH, 10, buffer address width (depth = 2^ADDR_WIDTH)
- DATA_WIDTH, 8, sample width
- PRE_TRIG, 512, samples stored before trigger; must be < depth

Ports:
- clk  in  1  system clock; sole clock
- rst  in  1  asynchronous, active-high reset
- ad_valid  in  1  sample strobe, already synchronous to clk
- ad_data  in  DATA_WIDTH  ADC sample, qualified by ad_valid
- wave_run  in  1  capture enable (level)
- trig_level  in  DATA_WIDTH  trigger threshold
- trig_edge  in  1  1 = rising, 0 = falling
- deci_rate  in  10  decimation ratio
- ram_refresh  in  1  re-arm request; rising edge significant
- wave_rd_addr  in  ADDR_WIDTH  buffer read address
- wave_rd_data  out  DATA_WIDTH  registered read data
- wave_ready  out  1  capture complete
- wave_trig_addr  out  ADDR_WIDTH  buffer address of trigger sample

Behaviour:
- Reset: wave_ready=0, wave_trig_addr=0, wave_rd_data=0, state IDLE, wr_ptr=0, all counters 0. RAM contents are not reset.
- Decimation:
  - deci_rate latched into deci_lat on entry to PRE_FILL. deci_lat 0 or 1 means every sample.
  - For N>=2, deci_cnt counts valid samples 0..N-1; a sample is accepted when ad_valid && deci_cnt==0. deci_cnt wraps N-1 -> 0 and clears on entry to PRE_FILL.
- Accepted samples are written to RAM[wr_ptr]; wr_ptr increments mod 2^ADDR_WIDTH. No write occurs in IDLE or DONE.
- FSM:
  - IDLE -> PRE_FILL on wave_run==1. Clears wave_ready, wr_ptr, fill_cnt, prev_valid.
  - PRE_FILL: writes PRE_TRIG accepted samples, no trigger check. After the PRE_TRIG-th write -> ARMED.
  - ARMED: keeps writing circularly. Trigger on an accepted sample cur with prev_valid:
    - rising: prev < trig_level && cur >= trig_level
    - falling: prev >= trig_level && cur < trig_level
    - On trigger: wave_trig_addr <= wr_ptr (the trigger sample's address), then -> POST_FILL.
  - POST_FILL: the trigger sample counts as post sample 1. After depth-PRE_TRIG total post samples -> DONE.
  - DONE: wave_ready=1, registered, asserted the cycle after the final write. Holds until re-arm or abort.
- prev: last accepted sample, written in all capture states. prev_valid is set after the first accepted sample of a capture.
- trig_level and trig_edge are used live, not latched.
- Re-arm: a rising edge of ram_refresh (1-cycle delayed edge detect) in PRE_FILL, ARMED, POST_FILL or DONE restarts PRE_FILL. This clears wave_ready and re-latches deci_rate. A level held high causes exactly one restart.
- Abort: wave_run==0 in any state -> IDLE next cycle, wave_ready cleared. wave_trig_addr keeps its last value. wave_run has priority over ram_refresh.
- Read port: wave_rd_data <= RAM[wave_rd_addr] one clk after the address is presented, in every state.
  - During capture, reads return current contents.
  - Read/write of the same address in the same cycle returns old data.
- A trigger during PRE_FILL is ignored. If no trigger ever occurs, the block stays in ARMED indefinitely.

Decomposition:
- Package dso_pkg:
  - capture state enum (IDLE, PRE_FILL, ARMED, POST_FILL, DONE)
  - DSO_ADDR_WIDTH, DSO_DATA_WIDTH, DSO_DEPTH, DSO_PRE_TRIG constants
- One sub-module: dso_capture_ram, a simple dual-port RAM with 1 write port and 1 registered read port, 2^ADDR_WIDTH x DATA_WIDTH, inferred block RAM.

Test Plan:
- Rising trigger: deci_rate=0, ad_valid=1 each cycle, ad_data=k mod 256, trig_level=100, trig_edge=1, wave_run 0->1 -> wave_trig_addr=612, wave_ready after 1124 samples; read addr 612 -> 100, 611 -> 99, 99 -> 99.
- Falling trigger: same ramp, trig_edge=0, level 100 -> wave_trig_addr=768; read 768 -> 0, 767 -> 255.
- Decimation: deci_rate=4, same ramp, rising level 100 -> wave_trig_addr=537; read 537 -> 100, 538 -> 104, 536 -> 96; deci_rate changed to 8 mid-capture has no effect.
- Abort: drop wave_run during POST_FILL -> IDLE next cycle, wave_ready stays 0. Re-raise -> full new capture (PRE_TRIG samples before any trigger is accepted).
- Refresh: in DONE, ram_refresh held high 256 cycles -> wave_ready=0 next-but-one cycle, exactly one new capture, wave_ready reasserts once.
- Reset mid-ARMED: assert rst -> wave_ready=0, wave_trig_addr=0, wave_rd_data=0 immediately. After release, no writes until wave_run is seen high.
